// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode stage: field layout, opcodes and FSM states.
package isa_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned AUX_W  = 11;
    localparam int unsigned ADDR_W = 26;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned NREGS  = 32;

    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_LSB = 11;

    localparam logic [OP_W-1:0] OP_NOP  = 6'b110111;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FLUSH2 = 1'b1
    } id_state_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic [XLEN-1:0] ext_imm(input logic [OP_W-1:0] op,
                                                input logic [IMM_W-1:0] imm);
        if (op == OP_ANDI || op == OP_ORI)
            return {{(XLEN-IMM_W){1'b0}}, imm};
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through,
// one synchronous write port, asynchronous clear, r0 fixed at zero.
module reg_file
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rstd,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_W-1:0]  ra1,
    input  logic [REG_W-1:0]  ra2,
    output logic [XLEN-1:0]   rd1_c,
    output logic [XLEN-1:0]   rd2_c
);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_valid;

    assign wr_valid = we && (waddr != '0);

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd)
            mem <= '{default: '0};
        else if (wr_valid)
            mem[waddr] <= wdata;
    end

    // A same-cycle write to the register being read is forwarded.
    always_comb begin
        rd1_c = mem[ra1];
        rd2_c = mem[ra2];
        if (wr_valid && waddr == ra1) rd1_c = wdata;
        if (wr_valid && waddr == ra2) rd2_c = wdata;
        if (ra1 == '0) rd1_c = '0;
        if (ra2 == '0) rd2_c = '0;
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: field split, operand read, immediate extension,
// load-use hazard detection and flush bubbles toward the D/E register.
module id_stage
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rstd,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   ins_in,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   pc_out,
    output logic [OP_W-1:0]   op_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [AUX_W-1:0]  aux_out,
    output logic [XLEN-1:0]   imm_dpl_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [XLEN-1:0]   os_out,
    output logic [XLEN-1:0]   ot_out,
    output logic              stall
);

    id_state_t        state, state_nxt;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs, rt;
    logic             hz;
    logic             bubble;

    assign op = ins_in[OP_LSB +: OP_W];
    assign rs = ins_in[RS_LSB +: REG_W];
    assign rt = ins_in[RT_LSB +: REG_W];

    assign pc_out      = pc_in;
    assign rt_out      = rt;
    assign rd_out      = ins_in[RD_LSB +: REG_W];
    assign aux_out     = ins_in[AUX_W-1:0];
    assign addr_out    = ins_in[ADDR_W-1:0];
    assign imm_dpl_out = ext_imm(op, ins_in[IMM_W-1:0]);
    assign op_out      = bubble ? OP_NOP : op;

    reg_file u_rf (
        .clk   (clk),
        .rstd  (rstd),
        .we    (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra1   (rs),
        .ra2   (rt),
        .rd1_c (os_out),
        .rd2_c (ot_out)
    );

    // A load in execute whose destination feeds this instruction.
    assign hz = (ex_op == OP_LW) && (ex_rt != '0) && (ex_rt == rs || ex_rt == rt);

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Flush outranks the hazard: the wrong-path instruction is dropped, not held.
    always_comb begin
        state_nxt = state;
        bubble    = 1'b0;
        stall     = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (flush) begin
                    bubble    = 1'b1;
                    state_nxt = ST_FLUSH2;
                end else if (hz) begin
                    bubble = 1'b1;
                    stall  = 1'b1;
                end
            end
            ST_FLUSH2: begin
                bubble    = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
        if (!rstd) begin
            bubble = 1'b1;
            stall  = 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a behavioural register-file/flush model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_id_stage;

    localparam logic [5:0] NOP  = 6'b110111;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] RTY  = 6'b000000;

    logic        clk = 1'b0;
    logic        rstd;
    logic [31:0] pc_in, ins_in, wb_data;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rt, wb_addr;
    logic        flush, wb_en;
    logic [31:0] pc_out, imm_dpl_out, os_out, ot_out;
    logic [5:0]  op_out;
    logic [4:0]  rt_out, rd_out;
    logic [10:0] aux_out;
    logic [25:0] addr_out;
    logic        stall;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    logic [31:0] mrf [32];
    int          flush_left = 0;

    id_stage dut (
        .clk(clk), .rstd(rstd), .pc_in(pc_in), .ins_in(ins_in),
        .ex_op(ex_op), .ex_rt(ex_rt), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_out(pc_out), .op_out(op_out), .rt_out(rt_out), .rd_out(rd_out),
        .aux_out(aux_out), .imm_dpl_out(imm_dpl_out), .addr_out(addr_out),
        .os_out(os_out), .ot_out(ot_out), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Model state: register contents and how many flush bubbles are still owed.
    always @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
            flush_left = 0;
        end else begin
            if (wb_en && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
            if (flush_left > 0) flush_left = flush_left - 1;
            else if (flush)     flush_left = 1;
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0]  op;
            logic [4:0]  rs, rt;
            logic [31:0] imm;
            bit          hz, bub, stl;
            op  = ins_in[31:26];
            rs  = ins_in[25:21];
            rt  = ins_in[20:16];
            hz  = (ex_op == LW) && ex_rt != 5'd0 && (ex_rt == rs || ex_rt == rt);
            bub = !rstd || flush_left > 0 || flush || hz;
            stl = rstd && flush_left == 0 && !flush && hz;
            if (op == ANDI || op == ORI) imm = {16'h0, ins_in[15:0]};
            else                         imm = {{16{ins_in[15]}}, ins_in[15:0]};
            chk("m_op",    32'(op_out),  bub ? 32'(NOP) : 32'(op));
            chk("m_stall", 32'(stall),   32'(stl));
            chk("m_os",    os_out,       m_read(rs));
            chk("m_ot",    ot_out,       m_read(rt));
            chk("m_imm",   imm_dpl_out,  imm);
            chk("m_pc",    pc_out,       pc_in);
            chk("m_rt",    32'(rt_out),  32'(rt));
            chk("m_rd",    32'(rd_out),  32'(ins_in[15:11]));
            chk("m_aux",   32'(aux_out), 32'(ins_in[10:0]));
            chk("m_addr",  32'(addr_out), 32'(ins_in[25:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pc_in = pc_in + 32'd4;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        ex_op = NOP;  ex_rt = 5'd0;
    endtask

    initial begin
        rstd = 1'b0; pc_in = 32'h1000; ins_in = 32'h0;
        idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        ins_in = mk_i(ORI, 5'd3, 5'd4, 16'h0001); ex_op = LW; ex_rt = 5'd3;
        settle();
        chk("rst_op", 32'(op_out), 32'(NOP));
        chk("rst_stall", 32'(stall), 32'h0);

        tick(); rstd = 1'b1; idle();
        ins_in = mk_i(RTY, 5'd1, 5'd2, 16'h2820);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        settle();
        tick(); idle();
        ins_in = mk_i(RTY, 5'd5, 5'd0, 16'h1234);
        settle();
        chk("wb_rd_os", os_out, 32'hDEADBEEF);
        chk("wb_rd_op", 32'(op_out), 32'(RTY));

        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        tick(); idle();
        ins_in = mk_i(RTY, 5'd0, 5'd0, 16'h0);
        settle();
        chk("r0_os", os_out, 32'h0);
        chk("r0_ot", ot_out, 32'h0);

        tick(); idle();
        ins_in = mk_i(RTY, 5'd5, 5'd7, 16'h0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000CAFE;
        settle();
        chk("bypass_ot", ot_out, 32'h0000CAFE);
        chk("bypass_os", os_out, 32'hDEADBEEF);

        for (int i = 1; i <= 4; i++) begin
            tick(); idle();
            wb_en = 1'b1; wb_addr = 5'(i + 10); wb_data = 32'(i) * 32'h01010101;
            ins_in = mk_i(RTY, 5'(i + 9), 5'(i + 10), 16'(i));
            settle();
        end

        tick(); idle();
        ins_in = mk_i(LW, 5'd1, 5'd2, 16'h8001);
        settle();
        chk("imm_lw", imm_dpl_out, 32'hFFFF8001);
        tick(); idle();
        ins_in = mk_i(ORI, 5'd1, 5'd2, 16'h8001);
        settle();
        chk("imm_ori", imm_dpl_out, 32'h00008001);
        tick(); idle();
        ins_in = mk_i(ANDI, 5'd1, 5'd2, 16'hFFFF);
        settle();
        chk("imm_andi", imm_dpl_out, 32'h0000FFFF);

        tick(); idle();
        ex_op = LW; ex_rt = 5'd3;
        ins_in = mk_i(ORI, 5'd3, 5'd4, 16'h0010);
        settle();
        chk("lu_stall", 32'(stall), 32'h1);
        chk("lu_op", 32'(op_out), 32'(NOP));
        tick(); idle();
        settle();
        chk("lu_after_stall", 32'(stall), 32'h0);
        chk("lu_after_op", 32'(op_out), 32'(ORI));
        tick(); idle();
        ex_op = LW; ex_rt = 5'd6;
        ins_in = mk_i(RTY, 5'd1, 5'd6, 16'h0);
        settle();
        chk("lu_rt_stall", 32'(stall), 32'h1);
        tick(); idle();
        ex_op = LW; ex_rt = 5'd0;
        ins_in = mk_i(ORI, 5'd0, 5'd0, 16'h0);
        settle();
        chk("lu_r0_stall", 32'(stall), 32'h0);
        chk("lu_r0_op", 32'(op_out), 32'(ORI));

        tick(); idle();
        flush = 1'b1;
        ins_in = mk_i(ORI, 5'd1, 5'd2, 16'h0003);
        settle();
        chk("fl1_op", 32'(op_out), 32'(NOP));
        chk("fl1_stall", 32'(stall), 32'h0);
        tick(); idle();
        settle();
        chk("fl2_op", 32'(op_out), 32'(NOP));
        tick(); idle();
        settle();
        chk("fl_done_op", 32'(op_out), 32'(ORI));

        tick(); idle();
        flush = 1'b1; ex_op = LW; ex_rt = 5'd3;
        ins_in = mk_i(ANDI, 5'd3, 5'd1, 16'h0);
        settle();
        chk("flhz_stall", 32'(stall), 32'h0);
        chk("flhz_op", 32'(op_out), 32'(NOP));
        tick(); idle();
        ex_op = LW; ex_rt = 5'd3;
        settle();
        chk("flhz2_stall", 32'(stall), 32'h0);
        tick(); idle();
        settle();
        chk("flhz_done_op", 32'(op_out), 32'(ANDI));

        tick(); idle();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000055;
        flush = 1'b1;
        ins_in = mk_i(ORI, 5'd9, 5'd5, 16'h0);
        settle();
        tick(); idle();
        ex_op = LW; ex_rt = 5'd9;
        #2 rstd = 1'b0;
        #1;
        chk("rst_mid_op", 32'(op_out), 32'(NOP));
        chk("rst_mid_stall", 32'(stall), 32'h0);
        settle();
        tick(); idle();
        rstd = 1'b1;
        settle();
        chk("post_rst_op", 32'(op_out), 32'(ORI));
        chk("post_rst_os", os_out, 32'h0);
        chk("post_rst_ot", ot_out, 32'h0);
        tick(); idle();
        settle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
